// File: rtl/sample_timer_if.sv
// Control and status bundle for the sample timer.
interface sample_timer_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 16
);
  logic              enable;
  logic              mode;
  logic              start;
  logic              stop;
  logic [WIDTH-1:0]  period;
  logic              capture_in;
  logic [WIDTH-1:0]  count;
  logic              tick;
  logic              done;
  logic              busy;
  logic [WRAP_W-1:0] wraps;
  logic [WIDTH-1:0]  capture_val;
  logic              capture_valid;

  modport master (
    output enable, mode, start, stop, period, capture_in,
    input  count, tick, done, busy, wraps, capture_val, capture_valid
  );

  modport slave (
    input  enable, mode, start, stop, period, capture_in,
    output count, tick, done, busy, wraps, capture_val, capture_valid
  );
endinterface

// File: rtl/sample_timer.sv
// Programmable sample timer: free-run / one-shot terminal counter with
// saturating wrap counter and timestamp capture on a sample strobe.
module sample_timer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 16
) (
  input  logic          clk_200,
  input  logic          reset_n,
  sample_timer_if.slave bus
);
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]  PERIOD_RST = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX   = '1;

  state_t            state, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  period_q, period_d;
  logic              mode_q, mode_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  cap_val_q, cap_val_d;
  logic              cap_vld_q, cap_vld_d;

  // Next-state and next-output logic; stop beats start, start beats counting.
  always_comb begin
    state_d   = state;
    count_d   = count_q;
    period_d  = period_q;
    mode_d    = mode_q;
    wraps_d   = wraps_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    cap_val_d = cap_val_q;
    cap_vld_d = 1'b0;

    // Timestamp is the count present in the strobe cycle (pre-wrap on terminal).
    if (state == RUN && bus.capture_in) begin
      cap_val_d = count_q;
      cap_vld_d = 1'b1;
    end

    case (state)
      IDLE: begin
        count_d = '0;
        if (bus.start && !bus.stop) begin
          state_d  = RUN;
          period_d = bus.period;
          mode_d   = bus.mode;
          wraps_d  = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.start) begin
          period_d = bus.period;
          mode_d   = bus.mode;
          count_d  = '0;
          wraps_d  = '0;
        end else if (bus.enable) begin
          if (count_q == period_q) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (wraps_q != WRAP_MAX) begin
              wraps_d = wraps_q + WRAP_W'(1);
            end
            if (mode_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_200) begin
    if (!reset_n) begin
      state     <= IDLE;
      count_q   <= '0;
      period_q  <= PERIOD_RST;
      mode_q    <= 1'b0;
      wraps_q   <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cap_val_q <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      state     <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      wraps_q   <= wraps_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cap_val_q <= cap_val_d;
      cap_vld_q <= cap_vld_d;
    end
  end

  assign bus.count         = count_q;
  assign bus.tick          = tick_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.wraps         = wraps_q;
  assign bus.capture_val   = cap_val_q;
  assign bus.capture_valid = cap_vld_q;
endmodule

// File: tb/tb_sample_timer.sv
// Bench for sample_timer: two instances (wide and 2-bit wrap counter) share
// stimulus; a model based on elapsed enabled cycles predicts every output.
module tb_sample_timer;
  logic       clk_200 = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0, capture_in = 1'b0;
  logic [3:0] period = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  sample_timer_if #(.WIDTH(4), .WRAP_W(16)) ifa ();
  sample_timer_if #(.WIDTH(4), .WRAP_W(2))  ifb ();

  assign ifa.enable = enable;  assign ifb.enable = enable;
  assign ifa.mode   = mode;    assign ifb.mode   = mode;
  assign ifa.start  = start;   assign ifb.start  = start;
  assign ifa.stop   = stop;    assign ifb.stop   = stop;
  assign ifa.period = period;  assign ifb.period = period;
  assign ifa.capture_in = capture_in;
  assign ifb.capture_in = capture_in;

  sample_timer #(.WIDTH(4), .WRAP_W(16)) dut_a (.clk_200(clk_200), .reset_n(reset_n), .bus(ifa));
  sample_timer #(.WIDTH(4), .WRAP_W(2))  dut_b (.clk_200(clk_200), .reset_n(reset_n), .bus(ifb));

  always #5 clk_200 = ~clk_200;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: n = enabled cycles since start; count = n mod (P+1), terminals = n / (P+1).
  bit m_run = 1'b0;
  bit m_mode = 1'b0;
  int m_p = 15;
  int m_n = 0;
  int m_hold_t = 0;
  bit e_tick = 1'b0, e_done = 1'b0, e_cvv = 1'b0;
  int e_cv = 0;

  function automatic int m_count();
    return m_run ? (m_n % (m_p + 1)) : 0;
  endfunction

  function automatic int m_wraps(input int maxv);
    int t;
    t = m_run ? (m_n / (m_p + 1)) : m_hold_t;
    return (t > maxv) ? maxv : t;
  endfunction

  always @(posedge clk_200) begin
    if (!reset_n) begin
      m_run = 1'b0; m_mode = 1'b0; m_p = 15; m_n = 0; m_hold_t = 0;
      e_tick = 1'b0; e_done = 1'b0; e_cvv = 1'b0; e_cv = 0;
    end else begin
      e_tick = 1'b0; e_done = 1'b0; e_cvv = 1'b0;
      if (m_run && capture_in) begin
        e_cvv = 1'b1;
        e_cv  = m_count();
      end
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1'b1; m_p = int'(period); m_mode = mode; m_n = 0;
        end
      end else if (stop) begin
        m_hold_t = m_n / (m_p + 1);
        m_run = 1'b0; m_n = 0;
      end else if (start) begin
        m_p = int'(period); m_mode = mode; m_n = 0;
      end else if (enable) begin
        m_n++;
        if (m_n % (m_p + 1) == 0) begin
          e_tick = 1'b1;
          if (m_mode) begin
            e_done = 1'b1;
            m_hold_t = 1;
            m_run = 1'b0; m_n = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk_200) begin
    if (cmp_en) begin
      chk("count_a", int'(ifa.count), m_count());
      chk("tick_a",  int'(ifa.tick),  int'(e_tick));
      chk("done_a",  int'(ifa.done),  int'(e_done));
      chk("busy_a",  int'(ifa.busy),  int'(m_run));
      chk("wraps_a", int'(ifa.wraps), m_wraps(65535));
      chk("capv_a",  int'(ifa.capture_valid), int'(e_cvv));
      chk("capval_a", int'(ifa.capture_val), e_cv);
      chk("count_b", int'(ifb.count), m_count());
      chk("tick_b",  int'(ifb.tick),  int'(e_tick));
      chk("done_b",  int'(ifb.done),  int'(e_done));
      chk("busy_b",  int'(ifb.busy),  int'(m_run));
      chk("wraps_b", int'(ifb.wraps), m_wraps(3));
      chk("capv_b",  int'(ifb.capture_valid), int'(e_cvv));
      chk("capval_b", int'(ifb.capture_val), e_cv);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk_200);
  endtask

  task automatic do_start(input logic [3:0] p, input logic m);
    period = p; mode = m; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int ticks;
    // Reset
    cyc(2);
    cmp_en = 1'b1;
    chk("rst_count", int'(ifa.count), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    reset_n = 1'b1;

    // Free-run, period 5
    enable = 1'b1;
    do_start(4'd5, 1'b0);
    chk("fr_busy", int'(ifa.busy), 1);
    chk("fr_count0", int'(ifa.count), 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ifa.tick) ticks++;
      if (i == 5) chk("fr_tick6", int'(ifa.tick), 1);
    end
    chk("fr_ticks", ticks, 3);
    chk("fr_wraps", int'(ifa.wraps), 3);
    chk("fr_count20", int'(ifa.count), 2);

    // Reset mid-RUN
    reset_n = 1'b0;
    cyc(2);
    chk("rm_count", int'(ifa.count), 0);
    chk("rm_busy", int'(ifa.busy), 0);
    chk("rm_wraps", int'(ifa.wraps), 0);
    chk("rm_tick", int'(ifa.tick), 0);
    reset_n = 1'b1;
    cyc(3);
    chk("rm_idle", int'(ifa.busy), 0);

    // Pause at count 2, period 3
    do_start(4'd3, 1'b0);
    cyc(2);
    chk("pa_count2", int'(ifa.count), 2);
    enable = 1'b0;
    cyc(4);
    chk("pa_hold", int'(ifa.count), 2);
    chk("pa_notick", int'(ifa.tick), 0);
    enable = 1'b1;
    cyc();
    chk("pa_count3", int'(ifa.count), 3);
    cyc();
    chk("pa_wrap", int'(ifa.count), 0);
    chk("pa_tick", int'(ifa.tick), 1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // One-shot, period 4
    do_start(4'd4, 1'b1);
    cyc(4);
    chk("os_count4", int'(ifa.count), 4);
    cyc();
    chk("os_tick", int'(ifa.tick), 1);
    chk("os_done", int'(ifa.done), 1);
    chk("os_busy", int'(ifa.busy), 0);
    chk("os_wraps", int'(ifa.wraps), 1);
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (ifa.tick) ticks++;
    end
    chk("os_noticks", ticks, 0);

    // start+stop together in IDLE
    period = 4'd5; mode = 1'b0; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle", int'(ifa.busy), 0);

    // Restart at count 7 with period 2
    do_start(4'd15, 1'b0);
    cyc(7);
    chk("rs_count7", int'(ifa.count), 7);
    do_start(4'd2, 1'b0);
    chk("rs_count0", int'(ifa.count), 0);
    chk("rs_wraps0", int'(ifa.wraps), 0);
    chk("rs_notick", int'(ifa.tick), 0);
    cyc(3);
    chk("rs_wrap", int'(ifa.count), 0);
    chk("rs_tick", int'(ifa.tick), 1);

    // Stop at count 3
    do_start(4'd15, 1'b0);
    cyc(3);
    chk("st_count3", int'(ifa.count), 3);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("st_busy", int'(ifa.busy), 0);
    chk("st_count", int'(ifa.count), 0);
    chk("st_tick", int'(ifa.tick), 0);

    // Capture at 9, at terminal, back-to-back, then in IDLE
    do_start(4'd15, 1'b0);
    cyc(9);
    capture_in = 1'b1; cyc(); capture_in = 1'b0;
    chk("cp_valid9", int'(ifa.capture_valid), 1);
    chk("cp_val9", int'(ifa.capture_val), 9);
    cyc();
    chk("cp_pulse", int'(ifa.capture_valid), 0);
    cyc(4);
    chk("cp_count15", int'(ifa.count), 15);
    capture_in = 1'b1; cyc();
    chk("cp_val15", int'(ifa.capture_val), 15);
    chk("cp_tick15", int'(ifa.tick), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("cp_b2b", int'(ifa.capture_val), i);
    end
    capture_in = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    capture_in = 1'b1; cyc(); capture_in = 1'b0;
    chk("cp_idle_v", int'(ifa.capture_valid), 0);
    chk("cp_idle_hold", int'(ifa.capture_val), 2);

    // Wrap saturation with period 0
    do_start(4'd0, 1'b0);
    cyc(10);
    chk("sat_b", int'(ifb.wraps), 3);
    chk("sat_a", int'(ifa.wraps), 10);
    chk("sat_tick", int'(ifb.tick), 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("sat_hold", int'(ifb.wraps), 3);
    cyc(2);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_timer.md
Name: sample_timer

Overview:
Parametrised successor to the free-running 5 ns sample timer on the 200 MHz sampling clock.
- Programmable terminal count; free-run and one-shot modes.
- Start/stop control, pause via enable.
- Terminal tick and one-shot done pulses, plus a saturating wrap counter.
- Timestamp capture of the current count on a sample strobe, used to tag SRAM sample events.

Parameters:
WIDTH, 4, count/period width in bits
WRAP_W, 16, width of saturating wrap counter

Ports:
clk_200  input  1  200 MHz sampling clock
reset_n  input  1  synchronous reset, active-low
enable  input  1  count enable; 0 pauses the count in RUN
mode  input  1  0 = free-run, 1 = one-shot; sampled on start
start  input  1  start/restart pulse
stop  input  1  abort; returns to IDLE
period  input  WIDTH  terminal count; sampled on start
capture_in  input  1  sample strobe; latch count
count  output  WIDTH  current count
tick  output  1  1-cycle pulse on each terminal-count wrap
done  output  1  1-cycle pulse when one-shot completes
busy  output  1  1 while in RUN
wraps  output  WRAP_W  terminal events since last start, saturating
capture_val  output  WIDTH  count latched on capture_in
capture_valid  output  1  1-cycle pulse, capture_val updated

Behaviour:
- All outputs are registered. Every state change takes effect at the rising edge of clk_200.
- Reset (reset_n=0 at an edge, overrides everything):
  - state=IDLE; count, tick, done, busy, wraps, capture_val, capture_valid = 0.
  - period_q = all ones; mode_q = 0.
  - Reset mid-RUN aborts with no tick or done.
- States:
  - IDLE: count held at 0, busy=0.
  - RUN: busy=1.
- IDLE -> RUN: start=1 and stop=0.
  - Latch period_q=period and mode_q=mode.
  - Next cycle: count=0, wraps=0, busy=1.
  - start is accepted regardless of enable.
- RUN, enable=1:
  - If count != period_q: count <= count+1.
  - If count == period_q (terminal): count <= 0, tick <= 1, wraps <= wraps+1.
  - Wraps saturates at 2^WRAP_W-1.
- Cycle length is period_q+1 cycles.
  - period=0: count stays 0 and tick fires every enabled cycle.
  - period=all ones with WIDTH=4: 16-state wrap, as in the current timer.
- RUN, enable=0: count, wraps and state frozen; tick=0; stop and start are still honoured.
- One-shot (mode_q=1): at the terminal event →
  - tick=1 and done=1 in the same cycle;
  - state=IDLE, busy=0, count=0;
  - wraps=1.
- Free-run (mode_q=0): never leaves RUN except by stop, start restart or reset.
- stop=1 in RUN:
  - Next cycle: IDLE, count=0, busy=0, no tick or done.
  - wraps is retained until the next start.
- stop in IDLE: no effect.
- start=1 and stop=1 together: stop wins, start is ignored.
- start in RUN (stop=0): restart.
  - Reload period_q and mode_q.
  - count=0, wraps=0, no tick or done for the abandoned cycle.
- Capture:
  - capture_in=1 while state=RUN → next cycle capture_val = count value present in the strobe cycle, capture_valid=1 for one cycle.
  - Applies even when enable=0.
  - Capture on a terminal cycle records period_q (pre-wrap value).
  - capture_in in IDLE is ignored; capture_val is held.
  - Back-to-back strobes give one capture per cycle.
- tick, done and capture_valid are single-cycle pulses; they are 0 in all other cycles.

Test Plan:
- Reset → outputs: assert reset_n=0 for 2 cycles mid-RUN → count=0, busy=0, wraps=0, no tick; after release, IDLE until start.
- Free-run: WIDTH=4, period=5, mode=0, start, enable=1 for 20 cycles → count 0,1,2,3,4,5,0,…; tick at cycles 6,12,18 after busy rises; wraps=3.
- Pause: period=3; hold enable=0 for 4 cycles at count=2 → count stays 2, no tick; on resume 3 then 0 with tick, no skipped or extra states.
- One-shot: period=4, mode=1 → count 0..4, then tick=done=1 in the same cycle, busy=0, count=0, wraps=1; further enable produces no ticks.
- Control conflicts:
  - start+stop together in IDLE → stays IDLE.
  - In RUN at count=7 (period=15), start with period=2 → count 0,1,2,0, wraps reset to 0.
  - stop at count=3 → IDLE next cycle, no tick.
- Capture and saturation:
  - capture_in at count=9 → capture_val=9, capture_valid pulse next cycle; capture on terminal with period=15 → capture_val=15; capture in IDLE → no pulse.
  - WRAP_W=2, period=0, free-run for 10 cycles → wraps saturates at 3.
